// File: rtl/ctrl_axil_regfile_pkg.sv
// Shared constants and state types for the AXI4-Lite kernel control register file.
package ctrl_pkg;

  localparam int unsigned AXI_ADDR_BITS = 6;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8;

  localparam logic [AXI_ADDR_BITS-1:0] ADDR_CTRL = 6'h00;
  localparam logic [AXI_ADDR_BITS-1:0] ADDR_GIE  = 6'h04;
  localparam logic [AXI_ADDR_BITS-1:0] ADDR_IER  = 6'h08;
  localparam logic [AXI_ADDR_BITS-1:0] ADDR_ISR  = 6'h0C;
  localparam logic [AXI_ADDR_BITS-1:0] ADDR_ARG0 = 6'h10;
  localparam logic [AXI_ADDR_BITS-1:0] ADDR_ARG1 = 6'h18;
  localparam logic [AXI_ADDR_BITS-1:0] ADDR_ARG2 = 6'h20;
  localparam logic [AXI_ADDR_BITS-1:0] ADDR_ARG3 = 6'h28;

  localparam int unsigned CTRL_AP_START     = 0;
  localparam int unsigned CTRL_AP_DONE      = 1;
  localparam int unsigned CTRL_AP_IDLE      = 2;
  localparam int unsigned CTRL_AP_READY     = 3;
  localparam int unsigned CTRL_AUTO_RESTART = 7;

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

  // Word-align a byte address; the low two bits carry no meaning in this map.
  function automatic logic [AXI_ADDR_BITS-1:0] word_addr(input logic [AXI_ADDR_BITS-1:0] a);
    return a & ~AXI_ADDR_BITS'(3);
  endfunction

endpackage

// File: rtl/ctrl_axil_regfile_if.sv
// AXI4-Lite control channel bundle between the host bridge (master) and the register file (slave).
interface ctrl_axil_regfile_if #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned STRB_BITS = DATA_BITS / 8
);
  logic                 AWVALID;
  logic                 AWREADY;
  logic [ADDR_BITS-1:0] AWADDR;
  logic                 WVALID;
  logic                 WREADY;
  logic [DATA_BITS-1:0] WDATA;
  logic [STRB_BITS-1:0] WSTRB;
  logic                 BVALID;
  logic                 BREADY;
  logic [1:0]           BRESP;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [ADDR_BITS-1:0] ARADDR;
  logic                 RVALID;
  logic                 RREADY;
  logic [DATA_BITS-1:0] RDATA;
  logic [1:0]           RRESP;

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/ctrl_ap_status.sv
// Kernel handshake state: ap_start, auto_restart, latched ap_done and, with CTRL_INTR_EN,
// the GIE/IER/ISR interrupt registers (tied to zero when the macro is undefined).
module ctrl_ap_status (
  input  logic       clock,
  input  logic       reset,
  input  logic       ctrl_we,
  input  logic       gie_we,
  input  logic       ier_we,
  input  logic       isr_we,
  input  logic [7:0] wr_byte,
  input  logic       ctrl_rd,
  input  logic       ap_done,
  input  logic       ap_ready,
  output logic       ap_start,
  output logic       auto_restart,
  output logic       ap_done_lat,
  output logic       gie,
  output logic [1:0] ier,
  output logic [1:0] isr,
  output logic       interrupt
);

  logic unused_bits;

  // A new done pulse outranks the clear-on-read of the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      ap_done_lat  <= 1'b0;
    end else begin
      if (ctrl_we && wr_byte[0])
        ap_start <= 1'b1;
      else if (ap_ready && !auto_restart)
        ap_start <= 1'b0;
      if (ctrl_we)
        auto_restart <= wr_byte[7];
      if (ap_done)
        ap_done_lat <= 1'b1;
      else if (ctrl_rd)
        ap_done_lat <= 1'b0;
    end
  end

`ifdef CTRL_INTR_EN
  logic [1:0] isr_ev;
  assign isr_ev = {ap_ready & ier[1], ap_done & ier[0]};

  // Kernel events outrank a host toggle on the same ISR bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      gie       <= 1'b0;
      ier       <= 2'b00;
      isr       <= 2'b00;
      interrupt <= 1'b0;
    end else begin
      if (gie_we)
        gie <= wr_byte[0];
      if (ier_we)
        ier <= wr_byte[1:0];
      for (int i = 0; i < 2; i++) begin
        if (isr_ev[i])
          isr[i] <= 1'b1;
        else if (isr_we && wr_byte[i])
          isr[i] <= ~isr[i];
      end
      interrupt <= gie & (|isr);
    end
  end

  assign unused_bits = ^wr_byte[6:2];
`else
  assign gie       = 1'b0;
  assign ier       = 2'b00;
  assign isr       = 2'b00;
  assign interrupt = 1'b0;

  assign unused_bits = ^{gie_we, ier_we, isr_we, wr_byte[6:1]};
`endif

endmodule

// File: rtl/ctrl_axil_regfile.sv
// AXI4-Lite control slave: write/read FSMs, scalar argument registers and read mux.
// Interrupt registers are present only when CTRL_INTR_EN is defined (see ctrl_ap_status).
module ctrl_axil_regfile
  import ctrl_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  ctrl_axil_regfile_if.slave       s_axi_control,
  output logic                     ap_start,
  input  logic                     ap_done,
  input  logic                     ap_idle,
  input  logic                     ap_ready,
  output logic [AXI_DATA_BITS-1:0] arg0,
  output logic [AXI_DATA_BITS-1:0] arg1,
  output logic [AXI_DATA_BITS-1:0] arg2,
  output logic [AXI_DATA_BITS-1:0] arg3,
  output logic                     interrupt
);

  wr_state_t                wr_state;
  rd_state_t                rd_state;
  logic [AXI_ADDR_BITS-1:0] wr_addr;
  logic                     awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [AXI_DATA_BITS-1:0] rdata_q, rd_mux;
  logic [AXI_DATA_BITS-1:0] args [4];
  logic                     aw_hs, w_hs, ar_hs;
  logic                     auto_restart, ap_done_lat, gie;
  logic [1:0]               ier, isr;

  assign aw_hs = s_axi_control.AWVALID & awready_q;
  assign w_hs  = s_axi_control.WVALID & wready_q;
  assign ar_hs = s_axi_control.ARVALID & arready_q;

  assign s_axi_control.AWREADY = awready_q;
  assign s_axi_control.WREADY  = wready_q;
  assign s_axi_control.BVALID  = bvalid_q;
  assign s_axi_control.BRESP   = 2'b00;
  assign s_axi_control.ARREADY = arready_q;
  assign s_axi_control.RVALID  = rvalid_q;
  assign s_axi_control.RDATA   = rdata_q;
  assign s_axi_control.RRESP   = 2'b00;

  // Write channel: AW, then W, then B, each in its own state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state  <= WRIDLE;
      wr_addr   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (wr_state)
        WRIDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            wr_addr   <= word_addr(s_axi_control.AWADDR);
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wr_state  <= WRDATA;
          end
        end
        WRDATA: if (w_hs) begin
          wready_q <= 1'b0;
          bvalid_q <= 1'b1;
          wr_state <= WRRESP;
        end
        WRRESP: if (s_axi_control.BREADY) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wr_state  <= WRIDLE;
        end
        default: wr_state <= WRIDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) args[i] <= '0;
    end else if (w_hs) begin
      for (int b = 0; b < AXI_STRB_BITS; b++) begin
        if (s_axi_control.WSTRB[b]) begin
          case (wr_addr)
            ADDR_ARG0: args[0][b*8 +: 8] <= s_axi_control.WDATA[b*8 +: 8];
            ADDR_ARG1: args[1][b*8 +: 8] <= s_axi_control.WDATA[b*8 +: 8];
            ADDR_ARG2: args[2][b*8 +: 8] <= s_axi_control.WDATA[b*8 +: 8];
            ADDR_ARG3: args[3][b*8 +: 8] <= s_axi_control.WDATA[b*8 +: 8];
            default: ;
          endcase
        end
      end
    end
  end

  assign arg0 = args[0];
  assign arg1 = args[1];
  assign arg2 = args[2];
  assign arg3 = args[3];

  ctrl_ap_status u_ap_status (
    .clock        (clock),
    .reset        (reset),
    .ctrl_we      (w_hs & s_axi_control.WSTRB[0] & (wr_addr == ADDR_CTRL)),
    .gie_we       (w_hs & s_axi_control.WSTRB[0] & (wr_addr == ADDR_GIE)),
    .ier_we       (w_hs & s_axi_control.WSTRB[0] & (wr_addr == ADDR_IER)),
    .isr_we       (w_hs & s_axi_control.WSTRB[0] & (wr_addr == ADDR_ISR)),
    .wr_byte      (s_axi_control.WDATA[7:0]),
    .ctrl_rd      (ar_hs & (word_addr(s_axi_control.ARADDR) == ADDR_CTRL)),
    .ap_done      (ap_done),
    .ap_ready     (ap_ready),
    .ap_start     (ap_start),
    .auto_restart (auto_restart),
    .ap_done_lat  (ap_done_lat),
    .gie          (gie),
    .ier          (ier),
    .isr          (isr),
    .interrupt    (interrupt)
  );

  // Read mux sees pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (word_addr(s_axi_control.ARADDR))
      ADDR_CTRL: begin
        rd_mux[CTRL_AP_START]     = ap_start;
        rd_mux[CTRL_AP_DONE]      = ap_done_lat;
        rd_mux[CTRL_AP_IDLE]      = ap_idle;
        rd_mux[CTRL_AP_READY]     = ap_ready;
        rd_mux[CTRL_AUTO_RESTART] = auto_restart;
      end
      ADDR_GIE:  rd_mux[0]   = gie;
      ADDR_IER:  rd_mux[1:0] = ier;
      ADDR_ISR:  rd_mux[1:0] = isr;
      ADDR_ARG0: rd_mux      = args[0];
      ADDR_ARG1: rd_mux      = args[1];
      ADDR_ARG2: rd_mux      = args[2];
      ADDR_ARG3: rd_mux      = args[3];
      default:   rd_mux      = '0;
    endcase
  end

  // Read channel: RDATA is captured at the AR handshake and held until RREADY.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state  <= RDIDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rd_state)
        RDIDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            rdata_q   <= rd_mux;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rd_state  <= RDDATA;
          end
        end
        RDDATA: if (s_axi_control.RREADY) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          rd_state  <= RDIDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_axil_regfile.sv
// Directed self-checking bench for ctrl_axil_regfile; expectations follow CTRL_INTR_EN when defined.
module tb_ctrl_axil_regfile;

  logic        clock;
  logic        reset;
  logic        ap_start, ap_done, ap_idle, ap_ready, interrupt;
  logic [31:0] arg0, arg1, arg2, arg3;
  logic [31:0] rd;
  logic [1:0]  resp;
  int          checks;
  int          errors;

  ctrl_axil_regfile_if #(.ADDR_BITS(6), .DATA_BITS(32)) s_axi_control ();

  ctrl_axil_regfile dut (
    .clock         (clock),
    .reset         (reset),
    .s_axi_control (s_axi_control),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .arg0          (arg0),
    .arg1          (arg1),
    .arg2          (arg2),
    .arg3          (arg3),
    .interrupt     (interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] bresp);
    int n;
    s_axi_control.AWVALID = 1'b1;
    s_axi_control.AWADDR  = addr;
    n = 0;
    while (!s_axi_control.AWREADY && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL aw_timeout addr %h", addr); end
    tick();
    s_axi_control.AWVALID = 1'b0;
    s_axi_control.WVALID  = 1'b1;
    s_axi_control.WDATA   = data;
    s_axi_control.WSTRB   = strb;
    n = 0;
    while (!s_axi_control.WREADY && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL w_timeout addr %h", addr); end
    tick();
    s_axi_control.WVALID = 1'b0;
    s_axi_control.BREADY = 1'b1;
    n = 0;
    while (!s_axi_control.BVALID && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL b_timeout addr %h", addr); end
    bresp = s_axi_control.BRESP;
    tick();
    s_axi_control.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    int n;
    s_axi_control.ARVALID = 1'b1;
    s_axi_control.ARADDR  = addr;
    n = 0;
    while (!s_axi_control.ARREADY && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL ar_timeout addr %h", addr); end
    tick();
    s_axi_control.ARVALID = 1'b0;
    s_axi_control.RREADY  = 1'b1;
    n = 0;
    while (!s_axi_control.RVALID && n < 50) begin tick(); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL r_timeout addr %h", addr); end
    data = s_axi_control.RDATA;
    tick();
    s_axi_control.RREADY = 1'b0;
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({s_axi_control.AWREADY, s_axi_control.WREADY, s_axi_control.BVALID,
         s_axi_control.ARREADY, s_axi_control.RVALID, ap_start, interrupt} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got aw%b w%b b%b ar%b r%b st%b irq%b want all 0",
               s_axi_control.AWREADY, s_axi_control.WREADY, s_axi_control.BVALID,
               s_axi_control.ARREADY, s_axi_control.RVALID, ap_start, interrupt);
    end
    checks++;
    if ({s_axi_control.RDATA, arg0, arg1, arg2, arg3} !== 160'd0) begin
      errors++;
      $display("FAIL reset_data got rdata %h args %h %h %h %h want 0",
               s_axi_control.RDATA, arg0, arg1, arg2, arg3);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s_axi_control.AWREADY !== 1'b1 || s_axi_control.ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got aw%b ar%b want 1 1",
               s_axi_control.AWREADY, s_axi_control.ARREADY);
    end
  endtask

  task automatic test_args();
    axi_write(6'h10, 32'hDEADBEEF, 4'hF, resp);
    axi_write(6'h10, 32'h000000AA, 4'h1, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL bresp got %b want 00", resp); end
    axi_read(6'h10, rd);
    checks++;
    if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL arg0_read got %h want deadbeaa", rd); end
    checks++;
    if (arg0 !== 32'hDEADBEAA) begin errors++; $display("FAIL arg0_port got %h want deadbeaa", arg0); end
    axi_write(6'h28, 32'h12345678, 4'b1010, resp);
    checks++;
    if (arg3 !== 32'h12005600) begin errors++; $display("FAIL arg3_strb got %h want 12005600", arg3); end
    axi_read(6'h14, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_14 got %h want 0", rd); end
    checks++;
    if (arg1 !== 32'h0 || arg2 !== 32'h0) begin
      errors++;
      $display("FAIL args_untouched got %h %h want 0 0", arg1, arg2);
    end
  endtask

  task automatic test_ap_start();
    axi_write(6'h00, 32'h01, 4'h1, resp);
    checks++;
    if (ap_start !== 1'b1) begin errors++; $display("FAIL ap_start_set got %b want 1", ap_start); end
    axi_write(6'h00, 32'h00, 4'h1, resp);
    checks++;
    if (ap_start !== 1'b1) begin errors++; $display("FAIL ap_start_w0 got %b want 1", ap_start); end
    pulse_ready();
    checks++;
    if (ap_start !== 1'b0) begin errors++; $display("FAIL ap_start_clr got %b want 0", ap_start); end
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    axi_read(6'h00, rd);
    checks++;
    if (rd !== 32'h06) begin errors++; $display("FAIL ctrl_done_rd got %h want 06", rd); end
    axi_read(6'h00, rd);
    checks++;
    if (rd !== 32'h04) begin errors++; $display("FAIL ctrl_done_cor got %h want 04", rd); end
  endtask

  task automatic test_auto_restart();
    axi_write(6'h00, 32'h81, 4'h1, resp);
    for (int i = 0; i < 3; i++) begin
      pulse_ready();
      tick();
      checks++;
      if (ap_start !== 1'b1) begin errors++; $display("FAIL auto_restart_%0d got %b want 1", i, ap_start); end
    end
    axi_read(6'h00, rd);
    checks++;
    if (rd !== 32'h85) begin errors++; $display("FAIL ctrl_auto_rd got %h want 85", rd); end
    axi_write(6'h00, 32'h00, 4'h1, resp);
    pulse_ready();
    checks++;
    if (ap_start !== 1'b0) begin errors++; $display("FAIL auto_off_clr got %b want 0", ap_start); end
  endtask

  task automatic test_intr();
`ifdef CTRL_INTR_EN
    axi_write(6'h04, 32'h1, 4'h1, resp);
    axi_write(6'h08, 32'h1, 4'h1, resp);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    tick();
    checks++;
    if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", interrupt); end
    axi_read(6'h0C, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL isr_rd got %h want 1", rd); end
    axi_write(6'h0C, 32'h1, 4'h1, resp);
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_clr got %b want 0", interrupt); end
    axi_read(6'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL isr_toggled got %h want 0", rd); end
    axi_write(6'h04, 32'h0, 4'h1, resp);
`else
    axi_write(6'h04, 32'h1, 4'h1, resp);
    axi_write(6'h08, 32'h3, 4'h1, resp);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    tick();
    axi_read(6'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL isr_off got %h want 0", rd); end
    axi_read(6'h04, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL gie_off got %h want 0", rd); end
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_off got %b want 0", interrupt); end
`endif
  endtask

  task automatic test_handshake();
    // Read with RREADY held low: data must hold.
    s_axi_control.ARVALID = 1'b1;
    s_axi_control.ARADDR  = 6'h10;
    tick();
    s_axi_control.ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_axi_control.RVALID !== 1'b1 || s_axi_control.RDATA !== 32'hDEADBEAA) begin
        errors++;
        $display("FAIL r_hold_%0d got v%b %h want v1 deadbeaa", i, s_axi_control.RVALID, s_axi_control.RDATA);
      end
      tick();
    end
    s_axi_control.RREADY = 1'b1;
    tick();
    s_axi_control.RREADY = 1'b0;
    checks++;
    if (s_axi_control.RVALID !== 1'b0) begin errors++; $display("FAIL r_release got %b want 0", s_axi_control.RVALID); end
    // W presented before AW.
    s_axi_control.WVALID = 1'b1;
    s_axi_control.WDATA  = 32'h0BADF00D;
    s_axi_control.WSTRB  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_axi_control.WREADY !== 1'b0) begin errors++; $display("FAIL w_early_%0d got %b want 0", i, s_axi_control.WREADY); end
      tick();
    end
    s_axi_control.AWVALID = 1'b1;
    s_axi_control.AWADDR  = 6'h18;
    tick();
    s_axi_control.AWVALID = 1'b0;
    tick();
    s_axi_control.WVALID = 1'b0;
    checks++;
    if (s_axi_control.BVALID !== 1'b1 || arg1 !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL w_early_apply got b%b %h want b1 0badf00d", s_axi_control.BVALID, arg1);
    end
    s_axi_control.BREADY = 1'b1;
    tick();
    s_axi_control.BREADY = 1'b0;
    axi_read(6'h3C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_3c got %h want 0", rd); end
    axi_read(6'h13, rd);
    checks++;
    if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL unaligned_13 got %h want deadbeaa", rd); end
    // Same-cycle read and write of arg0: read sees old value.
    s_axi_control.AWVALID = 1'b1;
    s_axi_control.AWADDR  = 6'h10;
    tick();
    s_axi_control.AWVALID = 1'b0;
    s_axi_control.WVALID  = 1'b1;
    s_axi_control.WDATA   = 32'h11111111;
    s_axi_control.WSTRB   = 4'hF;
    s_axi_control.ARVALID = 1'b1;
    s_axi_control.ARADDR  = 6'h10;
    tick();
    s_axi_control.WVALID  = 1'b0;
    s_axi_control.ARVALID = 1'b0;
    checks++;
    if (s_axi_control.RDATA !== 32'hDEADBEAA || arg0 !== 32'h11111111) begin
      errors++;
      $display("FAIL rw_same got rdata %h arg0 %h want deadbeaa 11111111", s_axi_control.RDATA, arg0);
    end
    s_axi_control.BREADY = 1'b1;
    s_axi_control.RREADY = 1'b1;
    tick();
    s_axi_control.BREADY = 1'b0;
    s_axi_control.RREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    axi_write(6'h00, 32'h01, 4'h1, resp);
    s_axi_control.AWVALID = 1'b1;
    s_axi_control.AWADDR  = 6'h20;
    tick();
    s_axi_control.AWVALID = 1'b0;
    checks++;
    if (s_axi_control.WREADY !== 1'b1) begin errors++; $display("FAIL mid_wrdata got %b want 1", s_axi_control.WREADY); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (s_axi_control.AWREADY !== 1'b1 || s_axi_control.WREADY !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle got aw%b w%b want 1 0", s_axi_control.AWREADY, s_axi_control.WREADY);
    end
    checks++;
    if ({arg0, arg1, arg2, arg3} !== 128'd0 || ap_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear got %h %h %h %h st%b want 0", arg0, arg1, arg2, arg3, ap_start);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ap_done = 1'b0;
    ap_idle = 1'b1;
    ap_ready = 1'b0;
    s_axi_control.AWVALID = 1'b0;
    s_axi_control.AWADDR  = '0;
    s_axi_control.WVALID  = 1'b0;
    s_axi_control.WDATA   = '0;
    s_axi_control.WSTRB   = '0;
    s_axi_control.BREADY  = 1'b0;
    s_axi_control.ARVALID = 1'b0;
    s_axi_control.ARADDR  = '0;
    s_axi_control.RREADY  = 1'b0;
    test_reset();
    test_args();
    test_ap_start();
    test_auto_restart();
    test_intr();
    test_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
